// File: rtl/adc_front_pkg.sv
// Shared constants and sample helpers for the ADC front end.
package adc_front_pkg;

    localparam int NCH_DEF      = 2;
    localparam int WIDTH_DEF    = 16;
    localparam int OVR_HOLD_DEF = 4096;
    localparam int PEAK_WIN_DEF = 1024;
    // Widest supported sample; helpers work on zero-extended values this wide.
    localparam int MAXW         = 24;

    // Undo ADC output randomization: when enabled and the LSB is set, every
    // bit above the LSB was XORed with it, so flip them back.
    function automatic logic [MAXW-1:0] derandomize(input logic [MAXW-1:0] s,
                                                     input logic            mode,
                                                     input int              w);
        logic [MAXW-1:0] flip;
        flip = '0;
        for (int i = 1; i < MAXW; i++) begin
            if (i < w) flip[i] = 1'b1;
        end
        return (mode && s[0]) ? (s ^ flip) : s;
    endfunction

    // |s| of a w-bit two's-complement value; the most-negative code has no
    // positive twin, so it clips to the largest positive magnitude.
    function automatic logic [MAXW-1:0] sat_abs(input logic [MAXW-1:0] s,
                                                 input int              w);
        logic [MAXW-1:0] mask;
        logic [MAXW-1:0] msb;
        logic [MAXW-1:0] neg;
        logic [MAXW-1:0] r;
        mask = '0;
        for (int i = 0; i < MAXW; i++) begin
            if (i < w) mask[i] = 1'b1;
        end
        msb = mask ^ (mask >> 1);
        neg = (~s + MAXW'(1)) & mask;
        if ((s & msb) == '0)  r = s & mask;
        else if (neg == msb)  r = mask >> 1;
        else                  r = neg;
        return r;
    endfunction

endpackage

// File: rtl/adc_derand_lane.sv
// One ADC channel: input register, de-randomizer, overrange stretcher and,
// when ADC_PEAK_HOLD_EN is defined, the per-window peak magnitude tracker.
module adc_derand_lane
    import adc_front_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int OVR_HOLD = OVR_HOLD_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ovr_i,
    input  logic             s1_valid_i,
    input  logic             s1_mode_i,
    input  logic             win_last_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             ovr_flag_o,
    output logic [WIDTH-2:0] peak_o
);

    localparam int CW = $clog2(OVR_HOLD);

    logic [WIDTH-1:0] s1_data_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] derand_s;
    logic [MAXW-1:0]  s1_ext;
    logic [MAXW-1:0]  derand_ext;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             flag_q, flag_d;

    // Stage 1 sample capture; held between valid samples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)        s1_data_q <= '0;
        else if (in_valid_i) s1_data_q <= data_i;
    end

    // De-randomize the stage 1 sample with the mode captured alongside it.
    always_comb begin
        s1_ext              = '0;
        s1_ext[WIDTH-1:0]   = s1_data_q;
        derand_ext          = derandomize(s1_ext, s1_mode_i, WIDTH);
        derand_s            = derand_ext[WIDTH-1:0];
    end

    // Stage 2 output register; holds its value while out_valid is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)        out_data_q <= '0;
        else if (s1_valid_i) out_data_q <= derand_s;
    end

    // Overrange stretch: flag goes high the clock after a trigger and stays
    // high while the counter still had time left, giving OVR_HOLD cycles.
    always_comb begin
        cnt_d  = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
        flag_d = (cnt_q != '0);
        if (in_valid_i && ovr_i) begin
            cnt_d  = CW'(OVR_HOLD - 1);
            flag_d = 1'b1;
        end
    end

    // Overrange counter and flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign out_data_o = out_data_q;
    assign ovr_flag_o = flag_q;

`ifdef ADC_PEAK_HOLD_EN
    logic [MAXW-1:0]  mag_ext;
    logic [WIDTH-2:0] mag, run_max, max_q, peak_q;

    // Magnitude of the sample entering the output stage and running max.
    always_comb begin
        mag_ext = sat_abs(derand_ext, WIDTH);
        mag     = mag_ext[WIDTH-2:0];
        run_max = (mag > max_q) ? mag : max_q;
    end

    // Track the window max; publish and clear on the window's last sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            max_q  <= '0;
            peak_q <= '0;
        end else if (s1_valid_i) begin
            if (win_last_i) begin
                peak_q <= run_max;
                max_q  <= '0;
            end else begin
                max_q  <= run_max;
            end
        end
    end

    assign peak_o = peak_q;
`else
    assign peak_o = '0;
`endif

endmodule

// File: rtl/adc_derand_multi.sv
// Multi-channel ADC de-randomizer. Owns the mode synchronizer, mode register,
// valid pipeline and peak window counter; per-channel work lives in the lanes.
// Define ADC_PEAK_HOLD_EN to build the peak tracker; otherwise peak outputs are 0.
module adc_derand_multi
    import adc_front_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int OVR_HOLD = OVR_HOLD_DEF,
    parameter int PEAK_WIN = PEAK_WIN_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     random,
    input  logic                     in_valid,
    input  logic [NCH*WIDTH-1:0]     adc_data,
    input  logic [NCH-1:0]           adc_ovr,
    output logic                     out_valid,
    output logic [NCH*WIDTH-1:0]     out_data,
    output logic [NCH-1:0]           ovr_flag,
    output logic [NCH*(WIDTH-1)-1:0] peak_data,
    output logic                     peak_valid
);

    localparam int STAGES = 2;

    logic              sync1_q, sync2_q;
    logic              mode_q, mode_d;
    logic              s1_mode_q;
    logic [STAGES:0]   vld_pipe;
    logic [STAGES:1]   vld_pipe_q;
    logic              win_last;

    // Two-flop synchronizer for the asynchronous mode input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= random;
            sync2_q <= sync1_q;
        end
    end

    // Mode only moves on sample boundaries; the accepted sample uses the
    // value latched on its own cycle.
    assign mode_d   = in_valid ? sync2_q : mode_q;
    assign vld_pipe = {vld_pipe_q, in_valid};

    // Mode register, stage 1 mode tag and valid shift register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q     <= 1'b0;
            s1_mode_q  <= 1'b0;
            vld_pipe_q <= '0;
        end else begin
            mode_q     <= mode_d;
            s1_mode_q  <= mode_d;
            vld_pipe_q <= vld_pipe[STAGES-1:0];
        end
    end

    assign out_valid = vld_pipe_q[STAGES];

`ifdef ADC_PEAK_HOLD_EN
    localparam int WW = $clog2(PEAK_WIN);
    logic [WW-1:0] win_cnt_q;
    logic          peak_valid_q;

    assign win_last = (win_cnt_q == WW'(PEAK_WIN - 1));

    // Count samples entering the output stage; pulse on the window's last.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt_q    <= '0;
            peak_valid_q <= 1'b0;
        end else begin
            peak_valid_q <= vld_pipe_q[1] && win_last;
            if (vld_pipe_q[1]) win_cnt_q <= win_last ? '0 : win_cnt_q + WW'(1);
        end
    end

    assign peak_valid = peak_valid_q;
`else
    assign win_last   = 1'b0;
    assign peak_valid = 1'b0;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        adc_derand_lane #(
            .WIDTH    (WIDTH),
            .OVR_HOLD (OVR_HOLD)
        ) u_lane (
            .clock      (clock),
            .reset_n    (reset_n),
            .in_valid_i (in_valid),
            .data_i     (adc_data[c*WIDTH +: WIDTH]),
            .ovr_i      (adc_ovr[c]),
            .s1_valid_i (vld_pipe_q[1]),
            .s1_mode_i  (s1_mode_q),
            .win_last_i (win_last),
            .out_data_o (out_data[c*WIDTH +: WIDTH]),
            .ovr_flag_o (ovr_flag[c]),
            .peak_o     (peak_data[c*(WIDTH-1) +: WIDTH-1])
        );
    end

endmodule

// File: doc/adc_derand_multi.md
ADC_DERAND_MULTI -- requirements
Module: adc_derand_multi

Interface
REQ-001 SHALL have parameter NCH, default 2, giving the number of ADC channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 16, giving sample width per channel in bits (8..24).
REQ-003 SHALL have parameter OVR_HOLD, default 4096, giving the overflow stretch length in clocks (>=2).
REQ-004 SHALL have parameter PEAK_WIN, default 1024, giving the peak window in valid samples (>=2).
REQ-005 clock  in  1  sole clock; all logic on its rising edge.
REQ-006 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-007 random  in  1  de-randomize enable, quasi-static, asynchronous to clock.
REQ-008 in_valid  in  1  adc_data/adc_ovr qualify this cycle.
REQ-009 adc_data  in  NCH*WIDTH  packed samples, channel 0 in LSBs.
REQ-010 adc_ovr  in  NCH  per-channel ADC overrange flags.
REQ-011 out_valid  out  1  out_data qualifies this cycle.
REQ-012 out_data  out  NCH*WIDTH  de-randomized samples, same packing as adc_data.
REQ-013 ovr_flag  out  NCH  stretched overrange indication per channel.
REQ-014 peak_data  out  NCH*(WIDTH-1)  per-channel peak magnitude of the last completed window.
REQ-015 peak_valid  out  1  one-cycle pulse when peak_data updates.

Function
REQ-016 SHALL pass random through a two-flop synchronizer; the synchronized value SHALL be latched into the mode register only on cycles with in_valid=1, so the mode changes only on sample boundaries.
REQ-017 SHALL register inputs in stage 1 and de-randomize in stage 2; out_valid SHALL equal in_valid delayed exactly 2 clocks; out_data SHALL be held when out_valid=0.
REQ-018 In mode=1 with sample bit 0 =1, out bits WIDTH-1..1 SHALL be the complement of input bits and bit 0 SHALL be passed; otherwise the sample SHALL pass unchanged.
REQ-019 The mode used for a sample SHALL be the mode register value in force when that sample was accepted.
REQ-020 Per channel, in_valid&adc_ovr SHALL load a hold counter with OVR_HOLD-1; the counter SHALL decrement each clock and saturate at 0.
REQ-021 ovr_flag SHALL be high from the clock after the triggering sample while the counter is nonzero, giving exactly OVR_HOLD high cycles for an isolated event; retriggering SHALL reload the counter without a low gap.
REQ-022 adc_ovr with in_valid=0 SHALL be ignored.
REQ-023 Peak magnitude SHALL be |sample| of the de-randomized value; the most-negative code SHALL saturate to 2^(WIDTH-1)-1.
REQ-024 The peak tracker SHALL count out_valid samples; on the PEAK_WIN-th sample it SHALL publish max over the window including that sample, pulse peak_valid for one clock, and restart with a cleared maximum.

Reset
REQ-025 On reset_n=0: out_valid, peak_valid, ovr_flag, out_data, peak_data, mode register, synchronizer, pipeline, hold counters, and window counter SHALL be 0, asynchronously.
REQ-026 Reset mid-window SHALL discard the partial window; the first window after reset SHALL contain exactly PEAK_WIN samples.

Configuration
REQ-027 Macro ADC_PEAK_HOLD_EN SHALL compile in the peak tracker (REQ-023, REQ-024).
REQ-028 Without ADC_PEAK_HOLD_EN, peak_data and peak_valid SHALL remain present, tied to 0, and no peak logic SHALL be synthesized; all other behaviour SHALL be unchanged.

Structure
REQ-029 Shared package adc_front_pkg SHALL hold default parameter constants and the derandomize and saturating-abs functions.
REQ-030 One sub-module adc_derand_lane SHALL implement a single channel (derandomize, ovr counter, peak) and SHALL be instantiated NCH times; the top level SHALL own the synchronizer, mode register, valid pipeline, and window counter.

Verification
REQ-031 random=1, WIDTH=16, sample 16'h0001 then 16'h1234 -> out 16'hFFFF then 16'h1234, each 2 clocks after acceptance.
REQ-032 random toggled 0->1 during in_valid=0 gap -> no output change until the next valid sample; that sample uses mode=1 only after the 2-flop sync delay.
REQ-033 OVR_HOLD=8, single adc_ovr pulse on ch1 -> ovr_flag[1] high exactly 8 clocks, ovr_flag[0] stays 0; second pulse at count 3 -> flag stays high 8 clocks past the second pulse.
REQ-034 PEAK_WIN=4, ch0 samples 5, -7, 3, -32768 -> peak_data ch0 = 32767, peak_valid single pulse; next window 1,1,1,2 -> 2.
REQ-035 reset_n asserted after 2 of 4 window samples, then released -> all outputs 0 immediately; next peak_valid after 4 fresh samples.
REQ-036 Build without ADC_PEAK_HOLD_EN -> peak_valid never asserts, peak_data 0, REQ-031/033 results identical.
